// File: rtl/alu_mdu_decoder.sv
// alu_mdu_decoder: execute-stage ALU op decoder for the RV32 core with an
// optional iterative RV32M multiply/divide unit (start/busy/done handshake).
// Build option: define ALU_MDU_DECODER_M_EN to include the RV32M decode, FSM
// and datapath; without it the MDU outputs are tied to zero.
module alu_mdu_decoder #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [6:0]    opcode,
    input  logic [2:0]    func3,
    input  logic [6:0]    func7,
    input  logic          start,
    input  logic          flush,
    input  logic [DW-1:0] rs1_val,
    input  logic [DW-1:0] rs2_val,
    output logic [3:0]    alu_control,
    output logic          is_mdu,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] mdu_result
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic mdu_sel;

`ifdef ALU_MDU_DECODER_M_EN
    assign mdu_sel = (opcode == OP_R) && (func7 == 7'b0000001);
`else
    assign mdu_sel = 1'b0;
`endif

    assign is_mdu = mdu_sel;

    // ALU operation select from opcode/func3/func7
    always_comb begin
        alu_control = 4'd0;
        if ((opcode == OP_R) || (opcode == OP_I)) begin
            case (func3)
                3'b000:  alu_control = ((opcode == OP_R) && func7[5]) ? 4'd1 : 4'd0;
                3'b001:  alu_control = 4'd2;
                3'b010:  alu_control = 4'd3;
                3'b011:  alu_control = 4'd4;
                3'b100:  alu_control = 4'd5;
                3'b101:  alu_control = func7[5] ? 4'd7 : 4'd6;
                3'b110:  alu_control = 4'd8;
                default: alu_control = 4'd9;
            endcase
            if (mdu_sel) begin
                alu_control = 4'd0;
            end
        end else if (opcode == OP_B) begin
            alu_control = 4'd1;
        end else if (opcode == OP_LUI) begin
            alu_control = 4'd10;
        end
    end

`ifdef ALU_MDU_DECODER_M_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    localparam int CW = $clog2(DW + 1);
    localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

    state_t          state, state_next;
    logic            accept;
    logic [CW-1:0]   count;
    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] acc_step;
    logic [DW-1:0]   opnd;
    logic [2:0]      op;
    logic            sign_a, sign_b;
    logic            sa, sb;
    logic [DW-1:0]   mag_a, mag_b;
    logic            div_zero, div_ovf, fast;
    logic [DW-1:0]   fast_result, final_result;
    logic [DW:0]     sum, trial;
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   quo_fix, rem_fix;
    logic [DW-1:0]   result;

    // Operand signs/magnitudes and the one-cycle special cases of divide
    always_comb begin
        if (!func3[2]) begin
            sa = (func3 != 3'b011) && rs1_val[DW-1];
            sb = !func3[1] && rs2_val[DW-1];
        end else begin
            sa = !func3[0] && rs1_val[DW-1];
            sb = !func3[0] && rs2_val[DW-1];
        end
        mag_a    = sa ? -rs1_val : rs1_val;
        mag_b    = sb ? -rs2_val : rs2_val;
        div_zero = func3[2] && (rs2_val == '0);
        div_ovf  = func3[2] && !func3[0] && (rs1_val == MINV) && (rs2_val == '1);
        fast     = div_zero || div_ovf;
        if (div_zero) begin
            fast_result = func3[1] ? rs1_val : '1;
        end else begin
            fast_result = func3[1] ? '0 : MINV;
        end
    end

    // One shift-add or restoring-divide step; acc holds {hi/rem, lo/quo}
    always_comb begin
        sum      = '0;
        trial    = '0;
        acc_step = acc;
        if (state == S_MUL) begin
            sum      = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opnd} : '0);
            acc_step = {sum, acc[DW-1:1]};
        end else if (state == S_DIV) begin
            trial = acc[2*DW-1:DW-1] - {1'b0, opnd};
            if (trial[DW]) begin
                acc_step = {acc[2*DW-2:0], 1'b0};
            end else begin
                acc_step = {trial[DW-1:0], acc[DW-2:0], 1'b1};
            end
        end
    end

    // Sign fixup and word select of the finished operation
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc_step : acc_step;
        quo_fix  = (sign_a ^ sign_b) ? -acc_step[DW-1:0] : acc_step[DW-1:0];
        rem_fix  = sign_a ? -acc_step[2*DW-1:DW] : acc_step[2*DW-1:DW];
        case (op)
            3'b000:                 final_result = prod_fix[DW-1:0];
            3'b001, 3'b010, 3'b011: final_result = prod_fix[2*DW-1:DW];
            3'b100, 3'b101:         final_result = quo_fix;
            default:                final_result = rem_fix;
        endcase
    end

    // MDU state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // MDU next state and handshake outputs; flush overrides everything
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = start && mdu_sel;
                if (start && mdu_sel && !flush) begin
                    accept = 1'b1;
                    if (fast) begin
                        state_next = S_FIN;
                    end else begin
                        state_next = func3[2] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                busy = 1'b1;
                if (count == '0) begin
                    state_next = S_FIN;
                end
            end
            S_FIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    // MDU datapath: capture on accept, iterate, register the result entering FIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            op     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            result <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (accept) begin
            op     <= func3;
            sign_a <= sa;
            sign_b <= sb;
            if (fast) begin
                count  <= '0;
                result <= fast_result;
            end else begin
                count <= CW'(DW - 1);
                // Multiplier / dividend go in the low half, the other operand stays fixed
                if (!func3[2]) begin
                    opnd <= mag_a;
                    acc  <= {{DW{1'b0}}, mag_b};
                end else begin
                    opnd <= mag_b;
                    acc  <= {{DW{1'b0}}, mag_a};
                end
            end
        end else if ((state == S_MUL) || (state == S_DIV)) begin
            acc <= acc_step;
            if (count == '0) begin
                result <= final_result;
            end else begin
                count <= count - CW'(1);
            end
        end
    end

    assign mdu_result = result;
`else
    logic unused_ok;

    assign unused_ok  = ^{clk, rst, start, flush, func7, rs1_val, rs2_val};
    assign busy       = 1'b0;
    assign done       = 1'b0;
    assign mdu_result = '0;
`endif

endmodule

// File: tb/tb_alu_mdu_decoder.sv
// tb_alu_mdu_decoder: self-checking bench for alu_mdu_decoder; decoder and MDU
// results are compared against a plain-arithmetic reference model.
module tb_alu_mdu_decoder;

    localparam int DW = 32;
`ifdef ALU_MDU_DECODER_M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [DW-1:0] MINV  = {1'b1, {(DW-1){1'b0}}};

    localparam logic [6:0] T_OP  [8] = '{OP_R, OP_R, OP_I, OP_LUI, OP_B, OP_JAL, 7'b1111111, OP_R};
    localparam logic [2:0] T_F3  [8] = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    localparam logic [6:0] T_F7  [8] = '{7'b0100000, 7'b0000000, 7'b0100000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0000001};
    localparam logic [3:0] T_EXP [8] = '{4'd1, 4'd0, 4'd7, 4'd10, 4'd1, 4'd0, 4'd0, 4'd0};

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic [2:0]    func3;
    logic [6:0]    func7;
    logic          start;
    logic          flush;
    logic [DW-1:0] rs1_val;
    logic [DW-1:0] rs2_val;
    logic [3:0]    alu_control;
    logic          is_mdu;
    logic          busy;
    logic          done;
    logic [DW-1:0] mdu_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mdu_decoder #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .start       (start),
        .flush       (flush),
        .rs1_val     (rs1_val),
        .rs2_val     (rs2_val),
        .alu_control (alu_control),
        .is_mdu      (is_mdu),
        .busy        (busy),
        .done        (done),
        .mdu_result  (mdu_result)
    );

    // Reference decode: func3 table plus the sub/sra/LUI/branch special cases
    function automatic logic [3:0] ref_alu(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        logic [3:0] base [8];
        logic [3:0] r;
        base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        r = 4'd0;
        if (M_EN && opc == OP_R && f7 == 7'b0000001) begin
            r = 4'd0;
        end else if (opc == OP_R || opc == OP_I) begin
            r = base[f3];
            if (f3 == 3'd0 && opc == OP_R && f7[5]) r = 4'd1;
            if (f3 == 3'd5 && f7[5]) r = 4'd7;
        end else if (opc == OP_B) begin
            r = 4'd1;
        end else if (opc == OP_LUI) begin
            r = 4'd10;
        end
        return r;
    endfunction

`ifdef ALU_MDU_DECODER_M_EN
    // Reference RV32M result using wide products and native signed divide
    function automatic logic [DW-1:0] ref_mdu(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] sa, sb, ua, ub, p;
        logic [DW-1:0]   r;
        logic            ovf;
        sa  = {{DW{a[DW-1]}}, a};
        sb  = {{DW{b[DW-1]}}, b};
        ua  = {{DW{1'b0}}, a};
        ub  = {{DW{1'b0}}, b};
        ovf = (a == MINV) && (b == '1);
        p   = '0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[DW-1:0]; end
            3'd1: begin p = sa * sb; r = p[2*DW-1:DW]; end
            3'd2: begin p = sa * ub; r = p[2*DW-1:DW]; end
            3'd3: begin p = ua * ub; r = p[2*DW-1:DW]; end
            3'd4: r = (b == '0) ? '1 : (ovf ? MINV : DW'($signed(a) / $signed(b)));
            3'd5: r = (b == '0) ? '1 : a / b;
            3'd6: r = (b == '0) ? a : (ovf ? '0 : DW'($signed(a) % $signed(b)));
            default: r = (b == '0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (f3[2] && (b == '0 || (!f3[0] && a == MINV && b == '1))) return 1;
        return DW + 1;
    endfunction

    // Drive one MDU request from a negedge; returns at the done negedge (or budget expiry)
    task automatic run_mdu(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output logic [DW-1:0] res, output int cycles, output int busy_cnt,
                           output logic busy0);
        opcode  = OP_R;
        func7   = 7'b0000001;
        func3   = f3;
        rs1_val = a;
        rs2_val = b;
        start   = 1'b1;
        #1 busy0 = busy;
        @(negedge clk);
        start    = 1'b0;
        rs1_val  = $urandom;
        rs2_val  = $urandom;
        func3    = 3'($urandom);
        cycles   = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && cycles < 100) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        res = mdu_result;
    endtask
`endif

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        opcode = '0; func3 = '0; func7 = '0; rs1_val = '0; rs2_val = '0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (mdu_result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", mdu_result); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_decode_directed();
        for (int i = 0; i < 8; i++) begin
            opcode = T_OP[i]; func3 = T_F3[i]; func7 = T_F7[i];
            #1;
            checks++;
            if (alu_control !== T_EXP[i]) begin
                errors++;
                $display("FAIL decode_dir[%0d]: alu_control %0d expected %0d", i, alu_control, T_EXP[i]);
            end
            checks++;
            if (is_mdu !== ((i == 7) && M_EN)) begin
                errors++;
                $display("FAIL is_mdu_dir[%0d]: got %b expected %b", i, is_mdu, (i == 7) && M_EN);
            end
        end
    endtask

    task automatic test_decode_random();
        logic [6:0] ops [10];
        logic [6:0] f7s [4];
        logic [3:0] e;
        ops = '{OP_R, OP_I, OP_B, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, 7'd0};
        f7s = '{7'b0000000, 7'b0100000, 7'b0000001, 7'd0};
        for (int i = 0; i < 300; i++) begin
            ops[9] = 7'($urandom);
            f7s[3] = 7'($urandom);
            opcode = ops[$urandom_range(0, 9)];
            func3  = 3'($urandom);
            func7  = f7s[$urandom_range(0, 3)];
            #1;
            e = ref_alu(opcode, func3, func7);
            checks++;
            if (alu_control !== e) begin
                errors++;
                $display("FAIL decode_rand op=%b f3=%b f7=%b: alu_control %0d expected %0d", opcode, func3, func7, alu_control, e);
            end
            checks++;
            if (is_mdu !== (M_EN && opcode == OP_R && func7 == 7'b0000001)) begin
                errors++;
                $display("FAIL is_mdu_rand op=%b f7=%b: got %b", opcode, func7, is_mdu);
            end
        end
    endtask

`ifdef ALU_MDU_DECODER_M_EN
    task automatic test_mdu_directed();
        logic [2:0]    f3s  [7] = '{3'd0, 3'd3, 3'd4, 3'd6, 3'd5, 3'd4, 3'd6};
        logic [DW-1:0] as   [7] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'h8000_0000};
        logic [DW-1:0] bs   [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [DW-1:0] exps [7] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        int            lats [7] = '{DW + 1, DW + 1, DW + 1, DW + 1, 1, 1, 1};
        logic [DW-1:0] res, held;
        int            cyc, bc;
        logic          b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            run_mdu(f3s[i], as[i], bs[i], res, cyc, bc, b0);
            checks++; if (res !== exps[i]) begin errors++; $display("FAIL mdu_dir[%0d]: result %h expected %h", i, res, exps[i]); end
            checks++; if (cyc !== lats[i]) begin errors++; $display("FAIL mdu_dir_lat[%0d]: %0d cycles expected %0d", i, cyc, lats[i]); end
            checks++; if (bc !== lats[i] - 1) begin errors++; $display("FAIL mdu_dir_busy[%0d]: busy %0d cycles expected %0d", i, bc, lats[i] - 1); end
            checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL mdu_dir_busy0[%0d]: got %b expected 1", i, b0); end
            held = res;
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse[%0d]: got %b expected 0", i, done); end
            repeat (2) @(negedge clk);
            checks++; if (mdu_result !== held) begin errors++; $display("FAIL result_hold[%0d]: got %h expected %h", i, mdu_result, held); end
        end
    endtask

    task automatic test_mdu_random();
        logic [2:0]    f3;
        logic [DW-1:0] a, b, res, e;
        int            cyc, bc, sel;
        logic          b0;
        for (int i = 0; i < 60; i++) begin
            f3  = 3'($urandom);
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = '0;
            if (sel == 1) begin a = MINV; b = '1; end
            if (sel == 2) b = DW'($urandom_range(1, 15));
            if (sel == 3) a = DW'($urandom_range(0, 255));
            e = ref_mdu(f3, a, b);
            @(negedge clk);
            run_mdu(f3, a, b, res, cyc, bc, b0);
            checks++;
            if (res !== e) begin
                errors++;
                $display("FAIL mdu_rand[%0d] f3=%0d a=%h b=%h: result %h expected %h", i, f3, a, b, res, e);
            end
            checks++;
            if (cyc !== exp_latency(f3, a, b)) begin
                errors++;
                $display("FAIL mdu_rand_lat[%0d] f3=%0d: %0d cycles expected %0d", i, f3, cyc, exp_latency(f3, a, b));
            end
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] res, prior;
        int            cyc, bc, dcnt;
        logic          b0;
        @(negedge clk);
        run_mdu(3'd0, 32'd7, 32'hFFFF_FFFD, prior, cyc, bc, b0);
        @(negedge clk);
        opcode = OP_R; func7 = 7'b0000001; func3 = 3'd5;
        rs1_val = 32'd1000; rs2_val = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt  = 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0 || dcnt != 0) begin errors++; $display("FAIL flush_done: done %b earlier pulses %0d expected none", done, dcnt); end
        checks++; if (mdu_result !== prior) begin errors++; $display("FAIL flush_result: got %h expected %h", mdu_result, prior); end
        run_mdu(3'd7, 32'd1000, 32'd7, res, cyc, bc, b0);
        checks++; if (res !== 32'd6) begin errors++; $display("FAIL flush_restart: result %h expected 6", res); end
        checks++; if (cyc !== DW + 1) begin errors++; $display("FAIL flush_restart_lat: %0d cycles expected %0d", cyc, DW + 1); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a, b, e, held;
        int            cyc, dcnt;
        a = $urandom; b = $urandom;
        e = ref_mdu(3'd1, a, b);
        @(negedge clk);
        opcode = OP_R; func7 = 7'b0000001; func3 = 3'd1; rs1_val = a; rs2_val = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        func3 = 3'd4; rs1_val = 32'd99; rs2_val = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 3;
        while (done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        checks++; if (mdu_result !== e) begin errors++; $display("FAIL busy_start_ignored: result %h expected %h", mdu_result, e); end
        checks++; if (cyc !== DW + 1) begin errors++; $display("FAIL busy_start_lat: %0d cycles expected %0d", cyc, DW + 1); end
        held = mdu_result;
        func3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fin_start_busy: got %b expected 0", busy); end
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        checks++; if (dcnt != 0) begin errors++; $display("FAIL fin_start_ignored: %0d done pulses expected 0", dcnt); end
        checks++; if (mdu_result !== held) begin errors++; $display("FAIL fin_start_hold: got %h expected %h", mdu_result, held); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] res;
        int            cyc, bc;
        logic          b0;
        @(negedge clk);
        opcode = OP_R; func7 = 7'b0000001; func3 = 3'd0;
        rs1_val = 32'd7; rs2_val = 32'hFFFF_FFFD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b expected 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        checks++; if (mdu_result !== '0) begin errors++; $display("FAIL rst_mid_result: got %h expected 0", mdu_result); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_mdu(3'd0, 32'd7, 32'hFFFF_FFFD, res, cyc, bc, b0);
        checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL rst_recover: result %h expected FFFFFFEB", res); end
    endtask
`else
    task automatic test_no_mdu();
        int bcnt, dcnt, rcnt;
        @(negedge clk);
        opcode = OP_R; func7 = 7'b0000001; func3 = 3'd0;
        rs1_val = 32'd7; rs2_val = 32'hFFFF_FFFD; start = 1'b1;
        #1;
        checks++; if (alu_control !== 4'd0) begin errors++; $display("FAIL nomdu_alu: got %0d expected 0", alu_control); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nomdu_busy0: got %b expected 0", busy); end
        bcnt = 0; dcnt = 0; rcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = (i < 3);
            func3 = 3'($urandom);
            if (busy !== 1'b0) bcnt++;
            if (done !== 1'b0) dcnt++;
            if (mdu_result !== '0) rcnt++;
        end
        start = 1'b0;
        checks++; if (bcnt != 0) begin errors++; $display("FAIL nomdu_busy: %0d busy cycles expected 0", bcnt); end
        checks++; if (dcnt != 0) begin errors++; $display("FAIL nomdu_done: %0d done cycles expected 0", dcnt); end
        checks++; if (rcnt != 0) begin errors++; $display("FAIL nomdu_result: %0d nonzero cycles expected 0", rcnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_decode_directed();
        test_decode_random();
`ifdef ALU_MDU_DECODER_M_EN
        test_mdu_directed();
        test_mdu_random();
        test_flush();
        test_back_to_back();
        test_reset_mid();
`else
        test_no_mdu();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
